// File: rtl/csr_trap_ctrl_pkg.sv
// Shared definitions for the CSR trap sequencer: FSM states, special cause codes,
// privilege encodings, CSR addresses, mstatus field positions and interrupt priority.
package csr_trap_ctrl_pkg;

   typedef enum logic [1:0] {
      TS_IDLE     = 2'd0,
      TS_COMMIT   = 2'd1,
      TS_REDIRECT = 2'd2
   } trap_state_t;

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_COMMIT   = 2'd1;
   localparam logic [1:0] ST_REDIRECT = 2'd2;

   // MRET/SRET ride on otherwise unused (custom) cause encodings
   localparam logic [4:0] EXC_II   = 5'd2;
   localparam logic [4:0] EXC_MRET = 5'd30;
   localparam logic [4:0] EXC_SRET = 5'd31;

   localparam logic [1:0] PRV_U = 2'b00;
   localparam logic [1:0] PRV_S = 2'b01;
   localparam logic [1:0] PRV_M = 2'b11;

   localparam logic [11:0] CSR_SSTATUS = 12'h100;
   localparam logic [11:0] CSR_SEPC    = 12'h141;
   localparam logic [11:0] CSR_SCAUSE  = 12'h142;
   localparam logic [11:0] CSR_STVAL   = 12'h143;
   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;
   localparam logic [11:0] CSR_MTVAL   = 12'h343;

   localparam int MS_SIE  = 1;
   localparam int MS_MIE  = 3;
   localparam int MS_SPIE = 5;
   localparam int MS_MPIE = 7;
   localparam int MS_SPP  = 8;
   localparam int MS_MPP  = 11;

   // Standard lines, highest priority first; lines >= 12 follow, highest index first
   localparam int INT_PRIO_N = 6;
   localparam int INT_PRIO [INT_PRIO_N] = '{11, 3, 7, 9, 1, 5};

endpackage

// File: rtl/csr_trap_ctrl_int_prio_sel.sv
// Fixed-priority pick over the masked interrupt lines; returns {valid, index}.
module int_prio_sel
   import csr_trap_ctrl_pkg::*;
#(
   parameter int INT_NUM = 16,
   parameter int IDX_W   = 5
)(
   input  logic [INT_NUM-1:0] req,
   output logic               valid,
   output logic [IDX_W-1:0]   index
);

   // Lowest priority is scanned first so that higher-priority hits overwrite it
   always_comb begin
      valid = 1'b0;
      index = '0;
      for (int i = 12; i < INT_NUM; i++) begin
         if (|(req & (INT_NUM'(1) << i))) begin
            valid = 1'b1;
            index = IDX_W'(i);
         end
      end
      for (int k = INT_PRIO_N - 1; k >= 0; k--) begin
         if (|(req & (INT_NUM'(1) << INT_PRIO[k]))) begin
            valid = 1'b1;
            index = IDX_W'(INT_PRIO[k]);
         end
      end
   end

endmodule

// File: rtl/csr_trap_ctrl.sv
// M/S-mode trap sequencer: delegation, interrupt select, trap CSR update and redirect.
// Optional CSR_TRAP_VECTOR_EN enables vectored interrupt targets when tvec[1:0]==1.
module csr_trap_ctrl
   import csr_trap_ctrl_pkg::*;
#(
   parameter int XLEN       = 64,
   parameter int VADDR_SIZE = 39,
   parameter int EXC_WIDTH  = 5,
   parameter int INT_NUM    = 16
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  trap_valid,
   output logic                  trap_ready,
   input  logic [EXC_WIDTH-1:0]  trap_exccode,
   input  logic [VADDR_SIZE-1:0] trap_pc,
   input  logic [XLEN-1:0]       trap_tval,
   input  logic                  int_take,
   input  logic [INT_NUM-1:0]    mip,
   input  logic [INT_NUM-1:0]    mie,
   input  logic [XLEN-1:0]       medeleg,
   input  logic [INT_NUM-1:0]    mideleg,
   input  logic [XLEN-1:0]       mtvec,
   input  logic [XLEN-1:0]       stvec,
   input  logic                  csr_wen,
   input  logic [11:0]           csr_waddr,
   input  logic [XLEN-1:0]       csr_wdata,
   output logic                  int_valid,
   output logic [EXC_WIDTH-1:0]  int_cause,
   output logic [1:0]            mode,
   output logic [XLEN-1:0]       mstatus_o,
   output logic [XLEN-1:0]       mepc,
   output logic [XLEN-1:0]       sepc,
   output logic [XLEN-1:0]       mcause,
   output logic [XLEN-1:0]       scause,
   output logic [XLEN-1:0]       mtval,
   output logic [XLEN-1:0]       stval,
   output logic                  redirect_valid,
   input  logic                  redirect_ready,
   output logic [VADDR_SIZE-1:0] target_pc
);

   logic [1:0]            state;
   logic                  st_mie, st_sie, st_mpie, st_spie, st_spp;
   logic [1:0]            st_mpp;

   logic                  req_int_p0;
   logic [EXC_WIDTH-1:0]  req_cause_p0;
   logic [VADDR_SIZE-1:0] req_pc_p0;
   logic [XLEN-1:0]       req_tval_p0;

   logic [INT_NUM-1:0]    pend, masked;
   logic                  m_ok, s_ok, sel_vld;
   logic [EXC_WIDTH-1:0]  sel_idx;

   logic                  is_mret, is_sret, illegal, do_ret_m, do_ret_s, to_s;
   logic [EXC_WIDTH-1:0]  eff_cause;
   logic [XLEN-1:0]       deleg_bits, tvec_sel, trap_tgt, next_target, cause_word, tval_word;

   // Interrupt eligibility: delegated lines are only visible below M
   always_comb begin
      pend   = mip & mie;
      m_ok   = (mode != PRV_M) || st_mie;
      s_ok   = (mode == PRV_U) || ((mode == PRV_S) && st_sie);
      masked = (pend & ~mideleg & {INT_NUM{m_ok}}) | (pend & mideleg & {INT_NUM{s_ok}});
   end

   int_prio_sel #(
      .INT_NUM (INT_NUM),
      .IDX_W   (EXC_WIDTH)
   ) u_int_prio_sel (
      .req   (masked),
      .valid (sel_vld),
      .index (sel_idx)
   );

   assign int_valid      = sel_vld && (state == ST_IDLE);
   assign int_cause      = sel_idx;
   assign trap_ready     = (state == ST_IDLE);
   assign redirect_valid = (state == ST_REDIRECT);

   // Decode of the captured request, evaluated in the COMMIT cycle
   always_comb begin
      is_mret     = !req_int_p0 && (req_cause_p0 == EXC_WIDTH'(EXC_MRET));
      is_sret     = !req_int_p0 && (req_cause_p0 == EXC_WIDTH'(EXC_SRET));
      illegal     = (is_mret && (mode != PRV_M)) || (is_sret && (mode == PRV_U));
      do_ret_m    = is_mret && !illegal;
      do_ret_s    = is_sret && !illegal;
      eff_cause   = illegal ? EXC_WIDTH'(EXC_II) : req_cause_p0;
      deleg_bits  = req_int_p0 ? XLEN'(mideleg) : medeleg;
      to_s        = (mode != PRV_M) && |(deleg_bits & (XLEN'(1) << eff_cause));
      tvec_sel    = to_s ? stvec : mtvec;
      trap_tgt    = tvec_sel & ~XLEN'(3);
`ifdef CSR_TRAP_VECTOR_EN
      if (req_int_p0 && (tvec_sel[1:0] == 2'b01))
         trap_tgt = trap_tgt + (XLEN'(eff_cause) << 2);
`endif
      next_target = do_ret_m ? mepc : (do_ret_s ? sepc : trap_tgt);
      cause_word  = {req_int_p0, (XLEN-1)'(eff_cause)};
      tval_word   = req_int_p0 ? '0 : req_tval_p0;
   end

   always_comb begin
      mstatus_o                 = '0;
      mstatus_o[MS_SIE]         = st_sie;
      mstatus_o[MS_MIE]         = st_mie;
      mstatus_o[MS_SPIE]        = st_spie;
      mstatus_o[MS_MPIE]        = st_mpie;
      mstatus_o[MS_SPP]         = st_spp;
      mstatus_o[MS_MPP +: 2]    = st_mpp;
   end

   // Request capture and redirect handshake
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         target_pc <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (trap_valid) begin
                  req_int_p0   <= 1'b0;
                  req_cause_p0 <= trap_exccode;
                  req_pc_p0    <= trap_pc;
                  req_tval_p0  <= trap_tval;
                  state        <= ST_COMMIT;
               end else if (int_take && int_valid) begin
                  req_int_p0   <= 1'b1;
                  req_cause_p0 <= int_cause;
                  req_pc_p0    <= trap_pc;
                  req_tval_p0  <= '0;
                  state        <= ST_COMMIT;
               end
            end
            ST_COMMIT: begin
               target_pc <= VADDR_SIZE'(next_target);
               state     <= ST_REDIRECT;
            end
            ST_REDIRECT: begin
               if (redirect_ready)
                  state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Trap CSR state: CSR-unit writes first, COMMIT updates override them
   always_ff @(posedge clk) begin
      if (rst) begin
         mode    <= PRV_M;
         st_mie  <= 1'b0;
         st_sie  <= 1'b0;
         st_mpie <= 1'b0;
         st_spie <= 1'b0;
         st_spp  <= 1'b0;
         st_mpp  <= PRV_U;
         mepc    <= '0;
         sepc    <= '0;
         mcause  <= '0;
         scause  <= '0;
         mtval   <= '0;
         stval   <= '0;
      end else begin
         if (csr_wen) begin
            case (csr_waddr)
               CSR_MEPC:    mepc   <= csr_wdata & ~XLEN'(1);
               CSR_SEPC:    sepc   <= csr_wdata & ~XLEN'(1);
               CSR_MCAUSE:  mcause <= csr_wdata;
               CSR_SCAUSE:  scause <= csr_wdata;
               CSR_MTVAL:   mtval  <= csr_wdata;
               CSR_STVAL:   stval  <= csr_wdata;
               CSR_MSTATUS: begin
                  st_sie  <= csr_wdata[MS_SIE];
                  st_mie  <= csr_wdata[MS_MIE];
                  st_spie <= csr_wdata[MS_SPIE];
                  st_mpie <= csr_wdata[MS_MPIE];
                  st_spp  <= csr_wdata[MS_SPP];
                  st_mpp  <= csr_wdata[MS_MPP +: 2];
               end
               CSR_SSTATUS: begin
                  st_sie  <= csr_wdata[MS_SIE];
                  st_spie <= csr_wdata[MS_SPIE];
                  st_spp  <= csr_wdata[MS_SPP];
               end
               default: ;
            endcase
         end
         if (state == ST_COMMIT) begin
            if (do_ret_m) begin
               mode    <= st_mpp;
               st_mie  <= st_mpie;
               st_mpie <= 1'b1;
               st_mpp  <= PRV_U;
            end else if (do_ret_s) begin
               mode    <= {1'b0, st_spp};
               st_sie  <= st_spie;
               st_spie <= 1'b1;
               st_spp  <= 1'b0;
            end else if (to_s) begin
               sepc    <= XLEN'(req_pc_p0);
               scause  <= cause_word;
               stval   <= tval_word;
               st_spie <= st_sie;
               st_sie  <= 1'b0;
               st_spp  <= mode[0];
               mode    <= PRV_S;
            end else begin
               mepc    <= XLEN'(req_pc_p0);
               mcause  <= cause_word;
               mtval   <= tval_word;
               st_mpie <= st_mie;
               st_mie  <= 1'b0;
               st_mpp  <= mode;
               mode    <= PRV_M;
            end
         end
      end
   end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Directed bench for csr_trap_ctrl: trap entry, delegation, returns, interrupt pick, redirect stall, reset.
module tb_csr_trap_ctrl;
   import csr_trap_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        trap_valid, trap_ready;
   logic [4:0]  trap_exccode;
   logic [38:0] trap_pc;
   logic [63:0] trap_tval;
   logic        int_take;
   logic [15:0] mip, mie, mideleg;
   logic [63:0] medeleg, mtvec, stvec;
   logic        csr_wen;
   logic [11:0] csr_waddr;
   logic [63:0] csr_wdata;
   logic        int_valid;
   logic [4:0]  int_cause;
   logic [1:0]  mode;
   logic [63:0] mstatus_o, mepc, sepc, mcause, scause, mtval, stval;
   logic        redirect_valid, redirect_ready;
   logic [38:0] target_pc;

   int vectors = 0;
   int miscompares = 0;
   logic [38:0] last_target;

   always #5 clk = ~clk;

   csr_trap_ctrl u_dut (
      .clk(clk), .rst(rst), .trap_valid(trap_valid), .trap_ready(trap_ready),
      .trap_exccode(trap_exccode), .trap_pc(trap_pc), .trap_tval(trap_tval),
      .int_take(int_take), .mip(mip), .mie(mie), .medeleg(medeleg), .mideleg(mideleg),
      .mtvec(mtvec), .stvec(stvec), .csr_wen(csr_wen), .csr_waddr(csr_waddr),
      .csr_wdata(csr_wdata), .int_valid(int_valid), .int_cause(int_cause), .mode(mode),
      .mstatus_o(mstatus_o), .mepc(mepc), .sepc(sepc), .mcause(mcause), .scause(scause),
      .mtval(mtval), .stval(stval), .redirect_valid(redirect_valid),
      .redirect_ready(redirect_ready), .target_pc(target_pc)
   );

   task automatic check_vec(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic csr_write(input logic [11:0] addr, input logic [63:0] data);
      csr_wen = 1'b1; csr_waddr = addr; csr_wdata = data;
      tick();
      csr_wen = 1'b0;
   endtask

   // One request through COMMIT and REDIRECT; optional CSR write in the COMMIT cycle
   task automatic run_trap(input logic [4:0] cause, input logic [38:0] pc, input logic [63:0] tval,
                           input logic is_int, input logic wen, input logic [11:0] waddr,
                           input logic [63:0] wdata, input int hold);
      int n;
      trap_pc = pc; trap_tval = tval; trap_exccode = cause;
      if (is_int) int_take = 1'b1;
      else        trap_valid = 1'b1;
      tick();
      trap_valid = 1'b0; int_take = 1'b0;
      check_vec("commit_busy", {63'd0, trap_ready}, 64'd0);
      check_vec("commit_int_valid", {63'd0, int_valid}, 64'd0);
      csr_wen = wen; csr_waddr = waddr; csr_wdata = wdata;
      tick();
      csr_wen = 1'b0;
      n = 2;
      while (!redirect_valid && n < 16) begin
         tick();
         n++;
      end
      check_vec("redirect_latency", 64'(n), 64'd2);
      last_target = target_pc;
      for (int i = 0; i < hold; i++) begin
         tick();
         check_vec("stall_valid", {63'd0, redirect_valid}, 64'd1);
         check_vec("stall_target", 64'(target_pc), 64'(last_target));
         check_vec("stall_ready", {63'd0, trap_ready}, 64'd0);
      end
      redirect_ready = 1'b1;
      tick();
      redirect_ready = 1'b0;
      check_vec("back_idle", {62'd0, trap_ready, redirect_valid}, 64'd2);
   endtask

   initial begin
      rst = 1'b1; trap_valid = 1'b0; trap_exccode = '0; trap_pc = '0; trap_tval = '0;
      int_take = 1'b0; mip = '0; mie = '0; mideleg = '0; medeleg = '0;
      mtvec = 64'h8000_0103; stvec = 64'h4000_0200;
      csr_wen = 1'b0; csr_waddr = '0; csr_wdata = '0; redirect_ready = 1'b0;
      tick(); tick();
      rst = 1'b0;
      check_vec("rst_mode", 64'(mode), 64'd3);
      check_vec("rst_ready", {63'd0, trap_ready}, 64'd1);
      check_vec("rst_redirect", {63'd0, redirect_valid}, 64'd0);
      check_vec("rst_mstatus", mstatus_o, 64'd0);
      check_vec("rst_mepc", mepc, 64'd0);
      check_vec("rst_target", 64'(target_pc), 64'd0);

      // M -> U through MRET with mpp=U
      run_trap(EXC_MRET, 39'h100, 64'd0, 1'b0, 1'b0, 12'h0, 64'd0, 0);
      check_vec("mret0_mode", 64'(mode), 64'd0);
      check_vec("mret0_mstatus", mstatus_o, 64'h80);

      // ecall from U, not delegated
      run_trap(5'd8, 39'h1234, 64'h77, 1'b0, 1'b0, 12'h0, 64'd0, 0);
      check_vec("ecall_mode", 64'(mode), 64'd3);
      check_vec("ecall_mcause", mcause, 64'd8);
      check_vec("ecall_mepc", mepc, 64'h1234);
      check_vec("ecall_mtval", mtval, 64'h77);
      check_vec("ecall_target", 64'(last_target), 64'h8000_0100);
      check_vec("ecall_mstatus", mstatus_o, 64'h0);

      run_trap(EXC_MRET, 39'h104, 64'd0, 1'b0, 1'b0, 12'h0, 64'd0, 0);
      check_vec("mret1_target", 64'(last_target), 64'h1234);
      check_vec("mret1_mode", 64'(mode), 64'd0);

      // Delegated store page fault from U
      medeleg = 64'h2000;
      run_trap(5'd13, 39'h2000, 64'hdead_beef, 1'b0, 1'b0, 12'h0, 64'd0, 0);
      check_vec("deleg_mode", 64'(mode), 64'd1);
      check_vec("deleg_scause", scause, 64'd13);
      check_vec("deleg_stval", stval, 64'hdead_beef);
      check_vec("deleg_sepc", sepc, 64'h2000);
      check_vec("deleg_mcause", mcause, 64'd8);
      check_vec("deleg_target", 64'(last_target), 64'h4000_0200);
      check_vec("deleg_mstatus", mstatus_o, 64'h80);

      // ecall from S goes to M, records mpp=S
      run_trap(5'd9, 39'h2800, 64'd0, 1'b0, 1'b0, 12'h0, 64'd0, 0);
      check_vec("ecall_s_mode", 64'(mode), 64'd3);
      check_vec("ecall_s_mcause", mcause, 64'd9);
      check_vec("ecall_s_mstatus", mstatus_o, 64'h800);

      csr_write(CSR_MSTATUS, 64'h880);
      csr_write(CSR_MEPC, 64'h3001);
      check_vec("csr_mepc", mepc, 64'h3000);
      check_vec("csr_mstatus", mstatus_o, 64'h880);

      run_trap(EXC_MRET, 39'h108, 64'd0, 1'b0, 1'b0, 12'h0, 64'd0, 0);
      check_vec("mret2_mode", 64'(mode), 64'd1);
      check_vec("mret2_mstatus", mstatus_o, 64'h88);
      check_vec("mret2_target", 64'(last_target), 64'h3000);

      run_trap(EXC_SRET, 39'h10c, 64'd0, 1'b0, 1'b0, 12'h0, 64'd0, 0);
      check_vec("sret_mode", 64'(mode), 64'd0);
      check_vec("sret_mstatus", mstatus_o, 64'hA8);
      check_vec("sret_target", 64'(last_target), 64'h2000);

      // SRET from U becomes illegal instruction; racing CSR write to mcause loses
      run_trap(EXC_SRET, 39'h5000, 64'd0, 1'b0, 1'b1, CSR_MCAUSE, 64'h55, 0);
      check_vec("ill_mode", 64'(mode), 64'd3);
      check_vec("ill_mcause", mcause, 64'd2);
      check_vec("ill_mepc", mepc, 64'h5000);
      check_vec("ill_mstatus", mstatus_o, 64'hA0);
      check_vec("ill_target", 64'(last_target), 64'h8000_0100);

      run_trap(EXC_MRET, 39'h110, 64'd0, 1'b0, 1'b0, 12'h0, 64'd0, 0);
      check_vec("mret3_mode", 64'(mode), 64'd0);
      check_vec("mret3_mstatus", mstatus_o, 64'hA8);

      // Interrupt priority in U
      mip = 16'h0888; mie = 16'h0888; #1;
      check_vec("prio_888_valid", {63'd0, int_valid}, 64'd1);
      check_vec("prio_888", 64'(int_cause), 64'd11);
      mip = 16'h0088; mie = 16'h0088; #1;
      check_vec("prio_088", 64'(int_cause), 64'd3);
      mip = 16'h00A0; mie = 16'h00A0; #1;
      check_vec("prio_0a0", 64'(int_cause), 64'd7);
      mip = 16'h6000; mie = 16'h6000; #1;
      check_vec("prio_6000", 64'(int_cause), 64'd14);
      mip = 16'h2020; mie = 16'h2020; #1;
      check_vec("prio_2020", 64'(int_cause), 64'd5);
      mip = 16'h0080; mie = 16'h0000; #1;
      check_vec("prio_unenabled", {63'd0, int_valid}, 64'd0);

      // Machine timer interrupt, redirect stalled for 5 cycles
      mtvec = 64'h1001; mip = 16'h0080; mie = 16'h0080; #1;
      check_vec("mti_valid", {63'd0, int_valid}, 64'd1);
      run_trap(5'd0, 39'h6000, 64'h99, 1'b1, 1'b0, 12'h0, 64'd0, 5);
      check_vec("mti_mode", 64'(mode), 64'd3);
      check_vec("mti_mcause", mcause, 64'h8000_0000_0000_0007);
      check_vec("mti_mepc", mepc, 64'h6000);
      check_vec("mti_mtval", mtval, 64'd0);
      check_vec("mti_mstatus", mstatus_o, 64'hA0);
`ifdef CSR_TRAP_VECTOR_EN
      check_vec("mti_target", 64'(last_target), 64'h101C);
`else
      check_vec("mti_target", 64'(last_target), 64'h1000);
`endif

      // Delegated line never taken while in M
      mideleg = 16'h0200; mip = 16'h0200; mie = 16'h0200; #1;
      check_vec("deleg_int_in_m", {63'd0, int_valid}, 64'd0);
      mip = '0; mie = '0;

      // Reset while in COMMIT: no redirect afterwards
      trap_exccode = 5'd8; trap_valid = 1'b1;
      tick();
      trap_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_vec("midrst_ready", {63'd0, trap_ready}, 64'd1);
      check_vec("midrst_redirect", {63'd0, redirect_valid}, 64'd0);
      check_vec("midrst_mcause", mcause, 64'd0);
      tick(); tick();
      check_vec("midrst_quiet", {63'd0, redirect_valid}, 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
